// File: rtl/dwt_input_pkg.sv
// dwt_input_pkg
//   Shared definitions for the DWT input packer: pairing state encoding,
//   default geometry/precision constants, the pixel normalisation function
//   and the pair-counter width helper.
package dwt_input_pkg;

  typedef enum logic {
    EVEN = 1'b0,  // no sample held
    ODD  = 1'b1   // even-position sample held, waiting for its partner
  } state_t;

  localparam int unsigned PIXEL_WIDTH = 8;
  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned POINT       = 10;
  localparam int unsigned MAX_SIDE    = 512;

  // Width of a counter able to hold 0 .. side/2 pairs.
  function automatic int unsigned cnt_width(input int unsigned side);
    return $clog2(side / 2 + 1);
  endfunction

  // Width-generic core of the normalisation: remove the DC offset of an
  // unsigned pw-bit pixel, then scale so the pixel MSB lands just below
  // the binary point of a pt-fraction-bit fixed-point sample. Exact.
  function automatic logic signed [31:0] normalize_w(input logic [31:0] pixel,
                                                     input int unsigned pw,
                                                     input int unsigned pt);
    logic signed [31:0] centered;
    centered = $signed(pixel) - $signed(32'(1) << (pw - 1));
    return centered <<< (pt - pw);
  endfunction

  // Normalisation at the package default widths.
  function automatic logic [DATA_WIDTH-1:0] normalize(input logic [PIXEL_WIDTH-1:0] pixel);
    return DATA_WIDTH'(normalize_w(32'(pixel), PIXEL_WIDTH, POINT));
  endfunction

endpackage

// File: rtl/dwt_input_packer.sv
// dwt_input_packer
//   Front end of the 2-D 9/7 DWT pipeline. Level-shifts and normalises a
//   raster stream of unsigned pixels and packs horizontally adjacent
//   samples into {odd, even} pairs carrying frame/line markers. Flags
//   malformed framing with sticky error bits.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   s_ready_o/s_valid_i      pixel handshake
//   s_sof_i, s_eol_i         first pixel of frame, last pixel of line
//   s_data_i                 unsigned pixel
//   m_ready_i/m_valid_o      pair handshake towards the DWT core
//   m_sof_o, m_eol_o         pair is first of frame / last of line
//   m_data_o                 {odd, even} normalised samples
//   err_odd_width_o          sticky: line ended on an even-position pixel
//   err_sof_o                sticky: SOF arrived while a sample was held
//   err_overflow_o           sticky: line longer than MaximumSideSize
//   line_pairs_o             pair count of the last completed line
module dwt_input_packer
  import dwt_input_pkg::*;
#(
  parameter int unsigned PixelWidth      = PIXEL_WIDTH,
  parameter int unsigned DataWidth       = DATA_WIDTH,
  parameter int unsigned Point           = POINT,
  parameter int unsigned MaximumSideSize = MAX_SIDE
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  output logic                                       s_ready_o,
  input  logic                                       s_valid_i,
  input  logic                                       s_sof_i,
  input  logic                                       s_eol_i,
  input  logic [PixelWidth-1:0]                      s_data_i,
  input  logic                                       m_ready_i,
  output logic                                       m_valid_o,
  output logic                                       m_sof_o,
  output logic                                       m_eol_o,
  output logic [2*DataWidth-1:0]                     m_data_o,
  output logic                                       err_odd_width_o,
  output logic                                       err_sof_o,
  output logic                                       err_overflow_o,
  output logic [$clog2(MaximumSideSize/2+1)-1:0]     line_pairs_o
);

  localparam int unsigned          CntWidth = cnt_width(MaximumSideSize);
  localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(MaximumSideSize / 2);

  state_t                 r_state;
  state_t                 w_state_next;

  logic [DataWidth-1:0]   w_norm;
  logic [DataWidth-1:0]   r_hold;
  logic                   r_hold_sof;

  logic                   r_m_valid;
  logic                   r_m_sof;
  logic                   r_m_eol;
  logic [2*DataWidth-1:0] r_m_data;

  logic                   r_err_odd;
  logic                   r_err_sof;
  logic                   r_err_ovf;
  logic [CntWidth-1:0]    r_cnt;
  logic [CntWidth-1:0]    r_line_pairs;

  logic                   w_accept;
  logic                   w_load;
  logic                   w_dup;
  logic                   w_hold_load;
  logic                   w_restart;
  logic                   w_pair_sof;
  logic                   w_pair_eol;
  logic [2*DataWidth-1:0] w_pair_data;

  logic [CntWidth-1:0]    w_cnt_base;
  logic                   w_cnt_sat;
  logic [CntWidth-1:0]    w_cnt_inc;

  assign w_norm    = DataWidth'(normalize_w(32'(s_data_i), PixelWidth, Point));

  // Output register is the only buffer: accept whenever it is empty or
  // being drained this cycle.
  assign s_ready_o = !r_m_valid || m_ready_i;
  assign w_accept  = s_valid_i && s_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= EVEN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dup        = 1'b0;
    w_hold_load  = 1'b0;
    w_restart    = 1'b0;
    w_pair_sof   = 1'b0;
    w_pair_eol   = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        EVEN: begin
          if (s_eol_i) begin
            // Lone even pixel closes the line: duplicate it into the odd slot.
            w_load     = 1'b1;
            w_dup      = 1'b1;
            w_pair_sof = s_sof_i;
            w_pair_eol = 1'b1;
          end else begin
            w_hold_load  = 1'b1;
            w_state_next = ODD;
          end
        end
        ODD: begin
          if (s_sof_i) begin
            // New frame started mid-pair: drop the held sample and restart
            // pairing with this pixel as the even sample.
            w_restart = 1'b1;
            if (s_eol_i) begin
              w_load       = 1'b1;
              w_dup        = 1'b1;
              w_pair_sof   = 1'b1;
              w_pair_eol   = 1'b1;
              w_state_next = EVEN;
            end else begin
              w_hold_load = 1'b1;
            end
          end else begin
            w_load       = 1'b1;
            w_pair_sof   = r_hold_sof;
            w_pair_eol   = s_eol_i;
            w_state_next = EVEN;
          end
        end
        default: w_state_next = EVEN;
      endcase
    end
  end

  assign w_pair_data = w_dup ? {w_norm, w_norm} : {w_norm, r_hold};

  // Counter value the new pair builds on; a mid-pair SOF restarts the line.
  assign w_cnt_base = w_restart ? '0 : r_cnt;
  assign w_cnt_sat  = (w_cnt_base == CntMax);
  assign w_cnt_inc  = w_cnt_sat ? CntMax : w_cnt_base + CntWidth'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold     <= '0;
      r_hold_sof <= 1'b0;
    end else if (w_hold_load) begin
      r_hold     <= w_norm;
      r_hold_sof <= s_sof_i;
    end
  end

  // One-entry ready/valid stage; data only changes on load, so it holds
  // steady while the core stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_m_valid <= 1'b0;
      r_m_sof   <= 1'b0;
      r_m_eol   <= 1'b0;
      r_m_data  <= '0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_sof   <= w_pair_sof;
      r_m_eol   <= w_pair_eol;
      r_m_data  <= w_pair_data;
    end else if (m_ready_i) begin
      r_m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt        <= '0;
      r_line_pairs <= '0;
      r_err_ovf    <= 1'b0;
    end else if (w_load) begin
      if (w_cnt_sat) begin
        r_err_ovf <= 1'b1;
      end
      if (w_pair_eol) begin
        r_line_pairs <= w_cnt_inc;
        r_cnt        <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end else if (w_restart) begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_odd <= 1'b0;
      r_err_sof <= 1'b0;
    end else begin
      if (w_load && w_dup) begin
        r_err_odd <= 1'b1;
      end
      if (w_restart) begin
        r_err_sof <= 1'b1;
      end
    end
  end

  assign m_valid_o       = r_m_valid;
  assign m_sof_o         = r_m_sof;
  assign m_eol_o         = r_m_eol;
  assign m_data_o        = r_m_data;
  assign err_odd_width_o = r_err_odd;
  assign err_sof_o       = r_err_sof;
  assign err_overflow_o  = r_err_ovf;
  assign line_pairs_o    = r_line_pairs;

endmodule

// File: tb/tb_dwt_input_packer.sv
// tb_dwt_input_packer
//   Directed bench for dwt_input_packer with a pixel-level reference model
//   and literal expectations for the documented scenarios.
module tb_dwt_input_packer;

  localparam int unsigned PW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned PT = 10;
  localparam int unsigned MS = 512;
  localparam int unsigned CW = $clog2(MS / 2 + 1);

  logic            clk_i;
  logic            rst_i;
  logic            s_ready_o;
  logic            s_valid_i;
  logic            s_sof_i;
  logic            s_eol_i;
  logic [PW-1:0]   s_data_i;
  logic            m_ready_i;
  logic            m_valid_o;
  logic            m_sof_o;
  logic            m_eol_o;
  logic [2*DW-1:0] m_data_o;
  logic            err_odd_width_o;
  logic            err_sof_o;
  logic            err_overflow_o;
  logic [CW-1:0]   line_pairs_o;

  dwt_input_packer #(
    .PixelWidth      (PW),
    .DataWidth       (DW),
    .Point           (PT),
    .MaximumSideSize (MS)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .s_ready_o       (s_ready_o),
    .s_valid_i       (s_valid_i),
    .s_sof_i         (s_sof_i),
    .s_eol_i         (s_eol_i),
    .s_data_i        (s_data_i),
    .m_ready_i       (m_ready_i),
    .m_valid_o       (m_valid_o),
    .m_sof_o         (m_sof_o),
    .m_eol_o         (m_eol_o),
    .m_data_o        (m_data_o),
    .err_odd_width_o (err_odd_width_o),
    .err_sof_o       (err_sof_o),
    .err_overflow_o  (err_overflow_o),
    .line_pairs_o    (line_pairs_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_have;
  bit            m_hsof;
  int            m_pix;
  int            m_cnt;
  int            m_lp;
  bit            e_odd;
  bit            e_sof;
  bit            e_ovf;
  logic [33:0]   exp_q[$];   // {sof, eol, {odd, even}}
  logic [33:0]   log_q[$];   // pairs taken from the DUT
  bit            saw_stall;

  function automatic logic [DW-1:0] nrm(input int p);
    int v;
    v = (p - (1 << (PW - 1))) * (1 << (PT - PW));
    return v[DW-1:0];
  endfunction

  function automatic void model_reset();
    m_have = 1'b0; m_hsof = 1'b0; m_pix = 0;
    m_cnt  = 0;    m_lp   = 0;
    e_odd  = 1'b0; e_sof  = 1'b0; e_ovf = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void emit(input bit sof, input bit eol, input logic [2*DW-1:0] d);
    exp_q.push_back({sof, eol, d});
    if (m_cnt == int'(MS / 2)) e_ovf = 1'b1;
    else m_cnt++;
    if (eol) begin
      m_lp  = m_cnt;
      m_cnt = 0;
    end
  endfunction

  function automatic void model_pixel(input int p, input bit sof, input bit eol);
    if (m_have && sof) begin
      e_sof  = 1'b1;
      m_cnt  = 0;
      m_have = 1'b0;
    end
    if (!m_have) begin
      if (eol) begin
        e_odd = 1'b1;
        emit(sof, 1'b1, {nrm(p), nrm(p)});
      end else begin
        m_have = 1'b1;
        m_pix  = p;
        m_hsof = sof;
      end
    end else begin
      emit(m_hsof, eol, {nrm(p), nrm(m_pix)});
      m_have = 1'b0;
    end
  endfunction

  // Check outputs every cycle mid-period, then advance the model for the
  // coming rising edge.
  always @(negedge clk_i) begin
    if (rst_i) model_reset();
    if (exp_q.size() == 0) begin
      chk("m_valid_idle", 64'(m_valid_o), 64'(0));
    end else begin
      chk("m_valid", 64'(m_valid_o), 64'(1));
      chk("m_data",  64'(m_data_o),  64'(exp_q[0][31:0]));
      chk("m_sof",   64'(m_sof_o),   64'(exp_q[0][33]));
      chk("m_eol",   64'(m_eol_o),   64'(exp_q[0][32]));
    end
    chk("s_ready",      64'(s_ready_o),       64'((exp_q.size() == 0) || m_ready_i));
    chk("err_odd",      64'(err_odd_width_o), 64'(e_odd));
    chk("err_sof",      64'(err_sof_o),       64'(e_sof));
    chk("err_ovf",      64'(err_overflow_o),  64'(e_ovf));
    chk("line_pairs",   64'(line_pairs_o),    64'(m_lp));
    if (!rst_i) begin
      if (s_valid_i && !s_ready_o) saw_stall = 1'b1;
      if (m_valid_o && m_ready_i) begin
        log_q.push_back({m_sof_o, m_eol_o, m_data_o});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_valid_i && s_ready_o) model_pixel(int'(s_data_i), s_sof_i, s_eol_i);
    end
  end

  // ---------------- sink ready driver ----------------
  int rmode = 0;  // 0: always ready, 1: stalled, 2: random 50%
  always @(posedge clk_i) begin
    #1;
    case (rmode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'b0;
      default: m_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int p, input bit sof, input bit eol);
    bit got;
    int n;
    s_valid_i = 1'b1;
    s_data_i  = PW'(p);
    s_sof_i   = sof;
    s_eol_i   = eol;
    got = 1'b0;
    n   = 0;
    while (!got && n < 1000) begin
      @(negedge clk_i);
      got = s_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pixel %0d not accepted within %0d cycles", p, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d pairs still expected, required 0", exp_q.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    rst_i     = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_s_ready",    64'(s_ready_o),       64'(1));
    chk("rst_m_valid",    64'(m_valid_o),       64'(0));
    chk("rst_m_data",     64'(m_data_o),        64'(0));
    chk("rst_line_pairs", 64'(line_pairs_o),    64'(0));
    chk("rst_errs",       64'({err_odd_width_o, err_sof_o, err_overflow_o}), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    log_q.delete();
    saw_stall = 1'b0;
  endtask

  task automatic chk_log(input string name, input int idx, input bit sof, input bit eol,
                         input logic [31:0] d);
    if (idx >= log_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: pair %0d missing, got %0d pairs", name, idx, log_q.size());
    end else begin
      chk({name, "_data"}, 64'(log_q[idx][31:0]), 64'(d));
      chk({name, "_sof"},  64'(log_q[idx][33]),   64'(sof));
      chk({name, "_eol"},  64'(log_q[idx][32]),   64'(eol));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b1;
    model_reset();

    // 4-pixel line
    do_reset();
    rmode = 0;
    send(0, 1'b1, 1'b0);
    send(255, 1'b0, 1'b0);
    send(128, 1'b0, 1'b0);
    send(64, 1'b0, 1'b1);
    drain();
    chk("t4_count", 64'(log_q.size()), 64'(2));
    chk_log("t4_p0", 0, 1'b1, 1'b0, 32'h01FC_FE00);
    chk_log("t4_p1", 1, 1'b0, 1'b1, 32'hFF00_0000);
    chk("t4_line_pairs", 64'(line_pairs_o), 64'(2));
    chk("t4_errs", 64'({err_odd_width_o, err_sof_o, err_overflow_o}), 64'(0));

    // Backpressure: 5 stalled cycles in a 16-pixel line
    do_reset();
    rmode = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(i * 16 + 3, i == 0, i == 15);
      end
      begin
        repeat (6) @(posedge clk_i);
        rmode = 1;
        repeat (5) @(posedge clk_i);
        rmode = 0;
      end
    join
    drain();
    chk("bp_stall_seen", 64'(saw_stall), 64'(1));
    chk("bp_count", 64'(log_q.size()), 64'(8));
    chk_log("bp_p0", 0, 1'b1, 1'b0, 32'hFE4C_FE0C);
    chk_log("bp_p7", 7, 1'b0, 1'b1, 32'h01CC_018C);
    chk("bp_line_pairs", 64'(line_pairs_o), 64'(8));

    // Odd width line
    do_reset();
    send(10, 1'b1, 1'b0);
    send(20, 1'b0, 1'b0);
    send(30, 1'b0, 1'b1);
    drain();
    chk("ow_count", 64'(log_q.size()), 64'(2));
    chk_log("ow_p0", 0, 1'b1, 1'b0, 32'hFE50_FE28);
    chk_log("ow_p1", 1, 1'b0, 1'b1, 32'hFE78_FE78);
    chk("ow_err_odd", 64'(err_odd_width_o), 64'(1));
    chk("ow_line_pairs", 64'(line_pairs_o), 64'(2));

    // SOF while a sample is held
    do_reset();
    send(1, 1'b1, 1'b0);
    send(2, 1'b1, 1'b0);
    send(3, 1'b0, 1'b0);
    drain();
    chk("sof_count", 64'(log_q.size()), 64'(1));
    chk_log("sof_p0", 0, 1'b1, 1'b0, 32'hFE0C_FE08);
    chk("sof_err", 64'(err_sof_o), 64'(1));

    // Over-long line
    do_reset();
    for (int i = 0; i < int'(MS) + 2; i++) send(i % 256, i == 0, i == int'(MS) + 1);
    drain();
    chk("ovf_count", 64'(log_q.size()), 64'(MS / 2 + 1));
    chk("ovf_err", 64'(err_overflow_o), 64'(1));
    chk("ovf_line_pairs", 64'(line_pairs_o), 64'(MS / 2));
    chk_log("ovf_last", int'(MS / 2), 1'b0, 1'b1, {nrm(1), nrm(0)});

    // Random 50% sink ready over a 64x4 frame
    do_reset();
    rmode = 2;
    for (int ln = 0; ln < 4; ln++) begin
      for (int x = 0; x < 64; x++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk_i);
          #1;
        end
        send(int'($urandom_range(0, 255)), (ln == 0) && (x == 0), x == 63);
      end
    end
    drain();
    rmode = 0;
    chk("rnd_count", 64'(log_q.size()), 64'(128));
    chk("rnd_line_pairs", 64'(line_pairs_o), 64'(32));
    chk("rnd_errs", 64'({err_odd_width_o, err_sof_o, err_overflow_o}), 64'(0));

    // Asynchronous reset with a pair waiting in the output register
    do_reset();
    rmode = 1;
    send(50, 1'b1, 1'b0);
    send(60, 1'b0, 1'b0);
    chk("ar_pre_valid", 64'(m_valid_o), 64'(1));
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk("ar_valid", 64'(m_valid_o), 64'(0));
    chk("ar_data",  64'(m_data_o),  64'(0));
    chk("ar_sof",   64'(m_sof_o),   64'(0));
    chk("ar_ready", 64'(s_ready_o), 64'(1));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rmode = 0;

    // Asynchronous reset with an even sample held
    send(70, 1'b0, 1'b0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    log_q.delete();
    send(100, 1'b0, 1'b0);
    send(200, 1'b0, 1'b0);
    drain();
    chk("ar_count", 64'(log_q.size()), 64'(1));
    chk_log("ar_p0", 0, 1'b0, 1'b0, 32'h0120_FF90);

    repeat (3) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dwt_input_packer.md
# dwt_input_packer

Front-end stage of the 2-D 9/7 DWT pipeline. Accepts a raster stream of unsigned pixels, one per beat, and applies DC level shift and fixed-point normalisation. It packs horizontally adjacent samples into `{odd, even}` pairs with frame and line markers, then drives the `s_*` port of the DWT core directly. It also flags malformed framing: odd line width, premature start-of-frame and over-long lines.

## Interface
- `PixelWidth`, 8: input pixel bits, unsigned.
- `DataWidth`, 16: width of each output sample, two's complement.
- `Point`, 10: fractional bits of an output sample. Must satisfy `Point >= PixelWidth` and `DataWidth >= Point + 1`.
- `MaximumSideSize`, 512: maximum line width in pixels. The pair counter is `$clog2(MaximumSideSize/2+1)` bits.
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `s_ready_o`, out, 1: pixel input ready.
- `s_valid_i`, in, 1: pixel valid.
- `s_sof_i`, in, 1: first pixel of frame.
- `s_eol_i`, in, 1: last pixel of line.
- `s_data_i`, in, PixelWidth: pixel value.
- `m_ready_i`, in, 1: DWT core ready.
- `m_valid_o`, out, 1: pair valid.
- `m_sof_o`, out, 1: pair is the first of the frame.
- `m_eol_o`, out, 1: pair is the last of the line.
- `m_data_o`, out, 2*DataWidth: `{odd, even}` normalised samples.
- `err_odd_width_o`, out, 1: sticky; a line ended on an even-position pixel.
- `err_sof_o`, out, 1: sticky; SOF arrived while an even sample was held.
- `err_overflow_o`, out, 1: sticky; a line exceeded `MaximumSideSize`.
- `line_pairs_o`, out, `$clog2(MaximumSideSize/2+1)`: number of pairs in the last completed line.

## Operation
- **Normalisation:** `n(p) = (p - 2^(PixelWidth-1)) * 2^(Point-PixelWidth)`, sign-extended to DataWidth. The result is exact with no rounding and cannot saturate.
- **State `EVEN`** (no held sample):
  - An accepted pixel is normalised into the hold register, together with its `s_sof_i`.
  - Move to `ODD`.
  - Exception: if `s_eol_i` is set on that pixel, emit `{n(p), n(p)}` immediately (odd slot duplicates the even slot), set `err_odd_width_o`, and stay in `EVEN`.
- **State `ODD`** (even sample held):
  - An accepted pixel with `s_sof_i=0` loads the output register with `{n(p), hold}`.
  - `m_sof_o` takes the held SOF; `m_eol_o` takes the current `s_eol_i`.
  - Move to `EVEN`.
- **SOF in `ODD`:**
  - Discard the held sample, set `err_sof_o`, and clear the pair counter.
  - Treat the pixel as a new even sample and stay in `ODD`.
  - If that pixel also has `s_eol_i`, apply the `EVEN` odd-width rule.
- **Pair counter:**
  - Increments on each pair loaded into the output register.
  - On an EOL pair, the count including that pair is copied to `line_pairs_o` and the counter clears.
  - An increment past `MaximumSideSize/2` sets `err_overflow_o` and holds the counter at its maximum. Pairs are still forwarded.
- **Errors:** all error flags are sticky until reset. No soft clear.

## Timing
- **Ready:** `s_ready_o = !m_valid_o || m_ready_i` in both states. This is combinational from `m_ready_i`, and is a deliberate simplification.
- **Latency:** `m_valid_o` rises the cycle after the completing pixel (odd pixel, or lone EOL pixel) is accepted.
- **Throughput:**
  - Sustained throughput is one pair per two input beats.
  - The output register reloads in the same cycle the current pair is taken (`m_valid_o && m_ready_i`), with no bubble.
- **Output hold:** `m_data_o`, `m_sof_o` and `m_eol_o` are stable while `m_valid_o && !m_ready_i`.
- **Reset:** asynchronous and immediate. All outputs and state go to 0:
  - state is `EVEN`;
  - `m_valid_o=0`, `m_sof_o=0`, `m_eol_o=0`, `m_data_o=0`;
  - all error flags 0;
  - `line_pairs_o=0` and the counter 0.
  - `s_ready_o` reads 1 during and after reset.
  - A pair partially held at reset is lost.
  - The first post-reset pixel is always treated as even, regardless of `s_sof_i`.

## Structure
- Package `dwt_input_pkg` holds:
  - the state enum `{EVEN, ODD}`;
  - the normalisation function `normalize(pixel)`, parameterised through the package's localparam defaults;
  - the counter-width helper.
- A single module with no sub-modules. The output register is an inline one-entry ready/valid stage.

## Test plan
- **4-pixel line:** send 0, 255, 128, 64 with SOF on the first and EOL on the last.
  - Expect pair `{0x01FC, 0xFE00}` with `m_sof_o=1`, `m_eol_o=0`.
  - Then `{0xFF00, 0x0000}` with `m_sof_o=0`, `m_eol_o=1`.
  - `line_pairs_o=2`, no errors.
- **Backpressure:** hold `m_ready_i=0` for 5 cycles during a 16-pixel line.
  - `s_ready_o` drops once the output register is full.
  - No pair is lost or duplicated; data is stable while stalled.
  - Random 50% `m_ready_i` over a 64×4 frame must match the reference model.
- **Odd width:** a 3-pixel line 10, 20, 30 with EOL on 30.
  - Pairs `{n(20), n(10)}`, then `{n(30), n(30)}` with EOL.
  - `err_odd_width_o=1`; `line_pairs_o=2`.
- **SOF mid-pair:** pixel A with SOF, then pixel B with SOF, then C.
  - Single pair `{n(C), n(B)}` with `m_sof_o=1`.
  - `err_sof_o=1`.
- **Overflow:** a line of `MaximumSideSize+2` pixels.
  - All `MaximumSideSize/2+1` pairs are forwarded and `err_overflow_o=1`.
  - `line_pairs_o` saturates at `MaximumSideSize/2`.
- **Reset mid-pair:** assert `rst_i` asynchronously while in `ODD` with `m_valid_o=1`.
  - Outputs go to 0 before the next clock edge.
  - After release, pixels X, Y produce `{n(Y), n(X)}`.
